// File: rtl/led_pattern_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Purpose  : Shared mode encodings for the LED pattern driver.
// Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_RUN_L  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_RUN_R  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'd2;
  localparam logic [MODE_W-1:0] MODE_BLINK  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/led_pattern_driver_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Enable-gated prescaler. Counts 0..CYCLES-1 and raises Tick
//            combinationally during the last count of each period.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic Enable,
  output logic Tick
);

  localparam int             CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);
  assign Tick      = w_at_last & Enable;

  // Count while enabled, wrap after the last value; hold when disabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else if (Enable) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_driver
// Purpose  : One flash LED plus CH_NUM run LEDs with four runtime-selectable
//            run patterns (run left, run right, bounce, blink-all). Mode
//            changes take effect only on step boundaries.
// Options  : LED_PWM_EN - adds Duty[3:0] input and 16-level PWM dimming of
//            the LED pins.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int CH_NUM       = 3,
  parameter int STEP_CYCLES  = 25_000_000,
  parameter int FLASH_CYCLES = 12_500_000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Enable,
  input  logic [MODE_W-1:0] Mode,
  input  logic              Mode_Load,
`ifdef LED_PWM_EN
  input  logic [3:0]        Duty,
`endif
  output logic              Mode_Pending,
  output logic              Step_Tick,
  output logic              Flash_LED,
  output logic [CH_NUM-1:0] Run_LED
);

  localparam logic [CH_NUM-1:0] SEED_LSB = CH_NUM'(1);
  localparam logic [CH_NUM-1:0] SEED_MSB = {1'b1, {(CH_NUM-1){1'b0}}};
  localparam logic [CH_NUM-1:0] SEED_ALL = {CH_NUM{1'b1}};

  // Starting pattern loaded whenever a mode is (re)applied.
  function automatic logic [CH_NUM-1:0] seed_of(input logic [MODE_W-1:0] m);
    logic [CH_NUM-1:0] s;
    s = SEED_LSB;
    case (m)
      MODE_RUN_L:  s = SEED_LSB;
      MODE_RUN_R:  s = SEED_MSB;
      MODE_BOUNCE: s = SEED_LSB;
      MODE_BLINK:  s = SEED_ALL;
      default:     s = SEED_LSB;
    endcase
    return s;
  endfunction

  logic              w_step_tick;
  logic              w_flash_tick;
  logic [MODE_W-1:0] w_new_mode;
  logic [CH_NUM-1:0] w_rotl;
  logic [CH_NUM-1:0] w_rotr;
  logic [CH_NUM-1:0] w_shl;
  logic [CH_NUM-1:0] w_shr;

  logic [MODE_W-1:0] r_mode;
  logic [MODE_W-1:0] r_pend_mode;
  logic              r_pending;
  logic              r_dir_up;
  logic [CH_NUM-1:0] r_run;
  logic              r_flash;
  logic              r_step_tick;

  tick_gen #(.CYCLES(STEP_CYCLES)) u_step_tick (
    .CLK    (CLK),
    .RST    (RST),
    .Enable (Enable),
    .Tick   (w_step_tick)
  );

  tick_gen #(.CYCLES(FLASH_CYCLES)) u_flash_tick (
    .CLK    (CLK),
    .RST    (RST),
    .Enable (Enable),
    .Tick   (w_flash_tick)
  );

  // A load coincident with the tick bypasses the pending register.
  assign w_new_mode = Mode_Load ? Mode : r_pend_mode;

  assign w_rotl = {r_run[CH_NUM-2:0], r_run[CH_NUM-1]};
  assign w_rotr = {r_run[0], r_run[CH_NUM-1:1]};
  assign w_shl  = {r_run[CH_NUM-2:0], 1'b0};
  assign w_shr  = {1'b0, r_run[CH_NUM-1:1]};

  // Mode capture, mode switch on step boundary and run pattern advance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mode      <= MODE_RUN_L;
      r_pend_mode <= MODE_RUN_L;
      r_pending   <= 1'b0;
      r_dir_up    <= 1'b1;
      r_run       <= SEED_LSB;
      r_step_tick <= 1'b0;
    end else begin
      r_step_tick <= w_step_tick;
      if (w_step_tick) begin
        if (Mode_Load || r_pending) begin
          // Switching (even to the same mode) re-seeds instead of advancing.
          r_mode    <= w_new_mode;
          r_run     <= seed_of(w_new_mode);
          r_dir_up  <= 1'b1;
          r_pending <= 1'b0;
        end else begin
          case (r_mode)
            MODE_RUN_L: r_run <= w_rotl;
            MODE_RUN_R: r_run <= w_rotr;
            MODE_BOUNCE: begin
              if (r_dir_up) begin
                r_run <= w_shl;
                if (w_shl[CH_NUM-1]) r_dir_up <= 1'b0;
              end else begin
                r_run <= w_shr;
                if (w_shr[0]) r_dir_up <= 1'b1;
              end
            end
            MODE_BLINK: r_run <= ~r_run;
            default:    r_run <= w_rotl;
          endcase
        end
      end else if (Mode_Load) begin
        // Last write wins while a change is pending.
        r_pend_mode <= Mode;
        r_pending   <= 1'b1;
      end
    end
  end

  // Flash LED toggles at each flash prescaler wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_flash <= 1'b0;
    end else if (w_flash_tick) begin
      r_flash <= ~r_flash;
    end
  end

  assign Mode_Pending = r_pending;
  assign Step_Tick    = r_step_tick;

`ifdef LED_PWM_EN
  logic [3:0] r_pwm_cnt;
  logic       w_pwm_on;

  // Free-running PWM phase counter, frozen together with the prescalers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pwm_cnt <= 4'd0;
    end else if (Enable) begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
    end
  end

  assign w_pwm_on  = (r_pwm_cnt < Duty);
  assign Run_LED   = r_run & {CH_NUM{w_pwm_on}};
  assign Flash_LED = r_flash & w_pwm_on;
`else
  assign Run_LED   = r_run;
  assign Flash_LED = r_flash;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_driver
// Purpose  : Self-checking bench for led_pattern_driver (CH_NUM=4,
//            STEP_CYCLES=4, FLASH_CYCLES=3). Expected run patterns are queued
//            by the stimulus and popped by a monitor on every Step_Tick.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_driver;

  localparam int CH = 4;
  localparam int SC = 4;
  localparam int FC = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          Enable = 1'b0;
  logic [1:0]    Mode = 2'd0;
  logic          Mode_Load = 1'b0;
  logic          Mode_Pending;
  logic          Step_Tick;
  logic          Flash_LED;
  logic [CH-1:0] Run_LED;
`ifdef LED_PWM_EN
  logic [3:0]    Duty = 4'd15;
`endif

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [CH-1:0] exp_q[$];
  bit            started = 1'b0;

  // Reference timing of the two prescalers.
  int            m_scnt  = 0;
  int            m_fcnt  = 0;
  logic          m_stick = 1'b0;
  logic          m_flash = 1'b0;

  led_pattern_driver #(
    .CH_NUM       (CH),
    .STEP_CYCLES  (SC),
    .FLASH_CYCLES (FC)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Enable       (Enable),
    .Mode         (Mode),
    .Mode_Load    (Mode_Load),
`ifdef LED_PWM_EN
    .Duty         (Duty),
`endif
    .Mode_Pending (Mode_Pending),
    .Step_Tick    (Step_Tick),
    .Flash_LED    (Flash_LED),
    .Run_LED      (Run_LED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timing reference: step tick and flash toggle positions.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_scnt  <= 0;
      m_fcnt  <= 0;
      m_stick <= 1'b0;
      m_flash <= 1'b0;
    end else if (Enable) begin
      m_stick <= (m_scnt == SC - 1);
      m_scnt  <= (m_scnt == SC - 1) ? 0 : m_scnt + 1;
      m_fcnt  <= (m_fcnt == FC - 1) ? 0 : m_fcnt + 1;
      if (m_fcnt == FC - 1) m_flash <= ~m_flash;
    end else begin
      m_stick <= 1'b0;
    end
  end

  // Monitor: timing checks each cycle, pattern scoreboard on each step.
  always @(negedge CLK) begin
    if (started && !RST) begin
      check("step_tick", 32'(Step_Tick), 32'(m_stick));
      check("flash_led", 32'(Flash_LED), 32'(m_flash));
      if (Step_Tick) begin
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_step: actual Run_LED %0h required no step", Run_LED);
        end else begin
          logic [CH-1:0] e;
          e = exp_q.pop_front();
          check("run_led", 32'(Run_LED), 32'(e));
        end
      end
    end
  end

  task automatic wait_steps(input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = 0;
      do begin
        @(negedge CLK);
        k++;
      end while (!Step_Tick && k < 40);
      if (!Step_Tick) begin
        n_assert++;
        n_fail++;
        $display("FAIL step_timeout: actual no Step_Tick in %0d cycles required a step", k);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 RST = 1'b1;
    Enable = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_run_led", 32'(Run_LED), 32'h1);
    check("reset_flash", 32'(Flash_LED), 32'h0);
    check("reset_step_tick", 32'(Step_Tick), 32'h0);
    check("reset_pending", 32'(Mode_Pending), 32'h0);
    RST = 1'b0;
    started = 1'b1;

    // 1: free-running RUN_L
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    wait_steps(4);

    // 2: BOUNCE loaded mid-step
    @(negedge CLK);
    Mode = 2'd2;
    Mode_Load = 1'b1;
    @(negedge CLK);
    Mode_Load = 1'b0;
    check("t2_pending_set", 32'(Mode_Pending), 32'h1);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    wait_steps(1);
    check("t2_pending_clear", 32'(Mode_Pending), 32'h0);
    wait_steps(6);

    // 3: BLINK loaded on the tick cycle
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1111);
    repeat (3) @(negedge CLK);
    Mode = 2'd3;
    Mode_Load = 1'b1;
    @(negedge CLK);
    Mode_Load = 1'b0;
    check("t3_no_pending", 32'(Mode_Pending), 32'h0);
    wait_steps(2);

    // 4: RUN_R overwritten by RUN_L before the tick
    @(negedge CLK);
    Mode = 2'd1;
    Mode_Load = 1'b1;
    @(negedge CLK);
    Mode = 2'd0;
    @(negedge CLK);
    Mode_Load = 1'b0;
    check("t4_pending", 32'(Mode_Pending), 32'h1);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    wait_steps(2);

    // 5: Enable dropped for 10 cycles mid-step
    exp_q.push_back(4'b0100);
    @(negedge CLK);
    Enable = 1'b0;
    repeat (10) @(negedge CLK);
    check("t5_frozen_run", 32'(Run_LED), 32'b0010);
    Enable = 1'b1;
    begin
      int k;
      k = 0;
      do begin
        @(negedge CLK);
        k++;
      end while (!Step_Tick && k < 20);
      check("t5_resume_len", 32'(k), 32'd3);
    end

    // 6: reset during BOUNCE direction down, with a pending mode
    @(negedge CLK);
    Mode = 2'd2;
    Mode_Load = 1'b1;
    @(negedge CLK);
    Mode_Load = 1'b0;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100);
    wait_steps(5);
    @(negedge CLK);
    Mode = 2'd3;
    Mode_Load = 1'b1;
    @(negedge CLK);
    Mode_Load = 1'b0;
    check("t6_pending_before_rst", 32'(Mode_Pending), 32'h1);
    RST = 1'b1;
    #1;
    check("t6_rst_run_led", 32'(Run_LED), 32'h1);
    check("t6_rst_flash", 32'(Flash_LED), 32'h0);
    check("t6_rst_pending", 32'(Mode_Pending), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    exp_q.push_back(4'b0010);
    wait_steps(1);

    repeat (3) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
